// File: rtl/bit_flopr.sv
// bit_flopr -- WIDTH-bit register, STAGES deep, with synchronous active-low clear
//              and a load enable that freezes the whole pipeline.
//
// Parameters
//   WIDTH      data width in bits (>=1)
//   STAGES     pipeline depth in clocks from i_a to o_y (>=1)
//   RESET_VAL  value loaded into every stage on clear
//
// Ports
//   clk        single clock, all state updates on its rising edge
//   i_sclr_n   synchronous clear, active-low; wins over i_en and i_a
//   i_en       1 = shift/load, 0 = hold every stage
//   i_a        data input
//   o_y        last pipeline stage (registered, no combinational path from i_a)
//   o_rise     per-bit rising-edge pulse on o_y (only with BFLOPR_RISE_EN)
//
// Build option
//   BFLOPR_RISE_EN  adds the o_rise port and its history register prev_y.
//
// Power-up contents are left undefined until the first clear.
module bit_flopr #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             i_sclr_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
`ifdef BFLOPR_RISE_EN
    output logic [WIDTH-1:0] o_rise,
`endif
    output logic [WIDTH-1:0] o_y
);

    // stage[0] takes i_a; stage[STAGES-1] drives o_y
    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stage[k] <= RESET_VAL;
            end
        end else if (i_en) begin
            stage[0] <= i_a;
            for (int unsigned k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign o_y = stage[STAGES-1];

`ifdef BFLOPR_RISE_EN
    // prev_y tracks o_y on every edge, held or not, so a level that stays
    // high under i_en=0 still yields only a single-cycle pulse.
    logic [WIDTH-1:0] prev_y;

    always_ff @(posedge clk) begin
        if (!i_sclr_n) begin
            prev_y <= RESET_VAL;
        end else begin
            prev_y <= o_y;
        end
    end

    assign o_rise = o_y & ~prev_y;
`endif

endmodule

// File: tb/tb_bit_flopr.sv
// Testbench for bit_flopr: a default 1-bit single flop and an 8-bit, 3-deep
// pipeline with a non-zero clear value, both driven from shared controls and
// compared against a queue-based reference model.
module tb_bit_flopr;

    localparam int unsigned STG = 3;
    localparam logic [7:0]  RV  = 8'h3C;

    logic       clk = 1'b0;
    logic       sclr_n = 1'b1;
    logic       en = 1'b0;
    logic       a1 = 1'b0;
    logic [7:0] a8 = '0;
    logic       y1;
    logic [7:0] y8;
`ifdef BFLOPR_RISE_EN
    logic       rise1;
    logic [7:0] rise8;
`endif

    int tests = 0;
    int fails = 0;

    // reference model: 1-bit flop value, 8-bit pipeline as a queue
    // (front = newest sample, back = what o_y shows), previous outputs for edges
    logic       m1_y = 1'bx;
    logic       m1_prev = 1'bx;
    logic [7:0] q8[$] = '{8'hxx, 8'hxx, 8'hxx};
    logic [7:0] m8_prev = 8'hxx;

    always #5 clk = ~clk;

    bit_flopr u_dut1 (
        .clk      (clk),
        .i_sclr_n (sclr_n),
        .i_en     (en),
        .i_a      (a1),
`ifdef BFLOPR_RISE_EN
        .o_rise   (rise1),
`endif
        .o_y      (y1)
    );

    bit_flopr #(
        .WIDTH     (8),
        .STAGES    (STG),
        .RESET_VAL (RV)
    ) u_dut8 (
        .clk      (clk),
        .i_sclr_n (sclr_n),
        .i_en     (en),
        .i_a      (a8),
`ifdef BFLOPR_RISE_EN
        .o_rise   (rise8),
`endif
        .o_y      (y8)
    );

    // drive on the falling edge, advance the model at the rising edge,
    // return 1 ns later so callers sample settled outputs
    task automatic step(input logic c, input logic e, input logic v1, input logic [7:0] v8);
        @(negedge clk);
        sclr_n = c;
        en     = e;
        a1     = v1;
        a8     = v8;
        @(posedge clk);
        m1_prev = m1_y;
        m8_prev = q8[$];
        if (!c) begin
            m1_y    = 1'b0;
            m1_prev = 1'b0;
            foreach (q8[k]) q8[k] = RV;
            m8_prev = RV;
        end else if (e) begin
            m1_y = v1;
            q8.push_front(v8);
            void'(q8.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        tests++;
        if (y1 !== 1'b0) begin
            fails++; $display("FAIL reset_y1 got %b want 0", y1);
        end
        tests++;
        if (y8 !== RV) begin
            fails++; $display("FAIL reset_y8 got %h want %h", y8, RV);
        end
    endtask

    task automatic test_load();
        step(1'b1, 1'b1, 1'b1, 8'h00);
        tests++;
        if (y1 !== 1'b1) begin
            fails++; $display("FAIL load_one got %b want 1", y1);
        end
        step(1'b1, 1'b1, 1'b0, 8'h00);
        tests++;
        if (y1 !== 1'b0) begin
            fails++; $display("FAIL load_zero got %b want 0", y1);
        end
    endtask

    task automatic test_hold();
        step(1'b1, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            tests++;
            if (y1 !== 1'b1) begin
                fails++; $display("FAIL hold_%0d got %b want 1", i, y1);
            end
        end
        step(1'b1, 1'b1, 1'b0, 8'h00);
        tests++;
        if (y1 !== 1'b0) begin
            fails++; $display("FAIL hold_release got %b want 0", y1);
        end
    endtask

    task automatic test_clear_priority();
        step(1'b1, 1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b1, 1'b1, 8'h77);
        tests++;
        if (y1 !== 1'b0) begin
            fails++; $display("FAIL clr_prio_y1 got %b want 0", y1);
        end
        tests++;
        if (y8 !== RV) begin
            fails++; $display("FAIL clr_prio_y8 got %h want %h", y8, RV);
        end
    endtask

    task automatic test_latency();
        logic [7:0] want [3];
        want = '{RV, RV, 8'hA5};
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'hA5);
        tests++;
        if (y8 !== want[0]) begin
            fails++; $display("FAIL lat_edge1 got %h want %h", y8, want[0]);
        end
        step(1'b1, 1'b1, 1'b0, 8'h11);
        tests++;
        if (y8 !== want[1]) begin
            fails++; $display("FAIL lat_edge2 got %h want %h", y8, want[1]);
        end
        step(1'b1, 1'b1, 1'b0, 8'h22);
        tests++;
        if (y8 !== want[2]) begin
            fails++; $display("FAIL lat_edge3 got %h want %h", y8, want[2]);
        end
        // mid-stream clear flushes 11/22 still in flight
        step(1'b0, 1'b1, 1'b0, 8'h33);
        tests++;
        if (y8 !== RV) begin
            fails++; $display("FAIL lat_flush got %h want %h", y8, RV);
        end
        step(1'b1, 1'b1, 1'b0, 8'h5A);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        tests++;
        if (y8 !== RV) begin
            fails++; $display("FAIL lat_refill2 got %h want %h", y8, RV);
        end
        step(1'b1, 1'b1, 1'b0, 8'h00);
        tests++;
        if (y8 !== 8'h5A) begin
            fails++; $display("FAIL lat_refill3 got %h want 5a", y8);
        end
    endtask

`ifdef BFLOPR_RISE_EN
    task automatic test_rise();
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h00);
        tests++;
        if (rise1 !== 1'b1) begin
            fails++; $display("FAIL rise_pulse got %b want 1", rise1);
        end
        step(1'b1, 1'b1, 1'b1, 8'h00);
        tests++;
        if (rise1 !== 1'b0) begin
            fails++; $display("FAIL rise_second got %b want 0", rise1);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        tests++;
        if (rise1 !== 1'b0) begin
            fails++; $display("FAIL rise_hold got %b want 0", rise1);
        end
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        tests++;
        if (rise1 !== 1'b0 || rise8 !== 8'h00) begin
            fails++; $display("FAIL rise_clear got %b/%h want 0/00", rise1, rise8);
        end
    endtask
`endif

    task automatic test_random();
        logic c, e, v1;
        logic [7:0] v8;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) begin
            c  = ($urandom_range(0, 9) != 0);
            e  = $urandom_range(0, 2) != 0;
            v1 = 1'($urandom);
            v8 = 8'($urandom);
            step(c, e, v1, v8);
            tests++;
            if (y1 !== m1_y || y8 !== q8[$]) begin
                fails++;
                $display("FAIL rand_%0d y1/y8 got %b/%h want %b/%h", i, y1, y8, m1_y, q8[$]);
            end
`ifdef BFLOPR_RISE_EN
            tests++;
            if (rise1 !== (m1_y & ~m1_prev) || rise8 !== (q8[$] & ~m8_prev)) begin
                fails++;
                $display("FAIL rand_rise_%0d got %b/%h want %b/%h", i, rise1, rise8,
                         m1_y & ~m1_prev, q8[$] & ~m8_prev);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_hold();
        test_clear_priority();
        test_latency();
`ifdef BFLOPR_RISE_EN
        test_rise();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
